// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | nn_ctrl_pkg : shared types for the layer control blocks          |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package nn_ctrl_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/layer_output_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | layer_output_sequencer : gathers NN parallel neuron results and  |
// | replays them as a serial valid/ready stream.    Rev 1.0          |
// +-----------------------------------------------------------------+
module layer_output_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = DATA_WIDTH,
  parameter int IDX_W     = $clog2(NN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           o_valid,
  input  logic [NN*dataWidth-1:0] x_out,
  input  logic                    ds_ready,
  input  logic                    clr_err,
  output logic [dataWidth-1:0]    x_in,
  output logic                    x_valid,
  output logic                    x_last,
  output logic                    busy,
  output logic                    layer_done,
  output logic                    err_overrun,
  output logic                    err_dup,
  output logic [NN-1:0]           collected
);

  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NN - 1);

  state_t               state_q, state_d;
  logic [NN-1:0]        mask_q, mask_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [dataWidth-1:0] buf_q [NN];
  logic [dataWidth-1:0] buf_d [NN];
  logic                 err_dup_q, err_dup_d;
  logic                 err_ovr_q, err_ovr_d;

  logic                 cap_en_w, xfer_w, idx_last_w, send_w;
  logic [NN-1:0]        cap_w, dup_w, mask_nxt_w;

  // DONE doubles as the first capture cycle of the next frame.
  assign cap_en_w   = (state_q != SEND);
  assign send_w     = (state_q == SEND);
  assign idx_last_w = (idx_q == C_IDX_LAST);
  assign xfer_w     = send_w & ds_ready;

  generate
    for (genvar i = 0; i < NN; i++) begin : g_neuron
      assign cap_w[i]      = cap_en_w & o_valid[i] & ~mask_q[i];
      assign dup_w[i]      = cap_en_w & o_valid[i] & mask_q[i];
      assign mask_nxt_w[i] = mask_q[i] | cap_w[i];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    for (int i = 0; i < NN; i++) begin
      if (cap_w[i]) buf_d[i] = x_out[i*dataWidth +: dataWidth];
    end
    unique case (state_q)
      COLLECT: begin
        mask_d = mask_nxt_w;
        if (&mask_nxt_w) begin
          state_d = SEND;
          mask_d  = '0;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (xfer_w) begin
          if (idx_last_w) state_d = DONE;
          else            idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        mask_d  = mask_nxt_w;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    // Set beats clear when both happen in the same cycle.
    err_dup_d = (|dup_w) | (err_dup_q & ~clr_err);
    err_ovr_d = (send_w & (|o_valid)) | (err_ovr_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      mask_q    <= '0;
      idx_q     <= '0;
      err_dup_q <= 1'b0;
      err_ovr_q <= 1'b0;
      for (int i = 0; i < NN; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      err_dup_q <= err_dup_d;
      err_ovr_q <= err_ovr_d;
      for (int i = 0; i < NN; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign busy        = send_w;
  assign x_valid     = send_w;
  assign x_last      = send_w & idx_last_w;
  assign x_in        = send_w ? buf_q[idx_q] : '0;
  assign layer_done  = (state_q == DONE);
  assign err_dup     = err_dup_q;
  assign err_overrun = err_ovr_q;
  assign collected   = mask_q;

endmodule
`default_nettype wire
